wdata_burst_mngr: RTL and testbench

WDATA_BURST_MNGR -- requirements
Module: wdata_burst_mngr

---
 rtl/wdata_burst_mngr_if.sv | 45 ++++
 rtl/wdata_burst_mngr.sv | 177 +++++++++++++++++
 tb/tb_wdata_burst_mngr.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wdata_burst_mngr_if.sv
// -----------------------------------------------------------------------------
// wdata_burst_mngr_if
// Bundles the burst-request handshake, the AXI W channel and the completion
// pulse of wdata_burst_mngr.
//   master : the burst manager (takes requests, drives the W channel)
//   slave  : the environment (offers requests, accepts W beats)
// Signals:
//   req_valid/req_ready      request handshake
//   req_id/req_wdata/req_mask  burst ID, payload and byte masks (beat 0 in LSBs,
//                            mask bit 1 = byte not written)
//   wvalid/wready/wdata/wstrb/wlast  AXI W channel
//   finish_wd/finish_id      final-beat handshake pulse and its burst ID
// -----------------------------------------------------------------------------
interface wdata_burst_mngr_if #(
  parameter int DATA_W = 32,
  parameter int BEATS  = 4,
  parameter int ID_W   = 4
);
  localparam int STRB_W = DATA_W / 8;

  logic                       req_valid;
  logic                       req_ready;
  logic [ID_W-1:0]            req_id;
  logic [DATA_W*BEATS-1:0]    req_wdata;
  logic [STRB_W*BEATS-1:0]    req_mask;

  logic                       wvalid;
  logic                       wready;
  logic [DATA_W-1:0]          wdata;
  logic [STRB_W-1:0]          wstrb;
  logic                       wlast;

  logic                       finish_wd;
  logic [ID_W-1:0]            finish_id;

  modport master (
    input  req_valid, req_id, req_wdata, req_mask, wready,
    output req_ready, wvalid, wdata, wstrb, wlast, finish_wd, finish_id
  );

  modport slave (
    output req_valid, req_id, req_wdata, req_mask, wready,
    input  req_ready, wvalid, wdata, wstrb, wlast, finish_wd, finish_id
  );
endinterface

// File: rtl/wdata_burst_mngr.sv
// -----------------------------------------------------------------------------
// wdata_burst_mngr
// Captures fixed-length write bursts (ID, data, byte masks) and plays them out
// beat by beat on an AXI W channel. The first beat appears the cycle after the
// request is accepted; a request accepted on the final beat handshake of the
// current burst starts the next cycle with no idle gap.
//
// Ports:
//   clk    single clock, all state on the rising edge
//   rst_n  asynchronous active-low reset (aborts any burst in flight)
//   bus    wdata_burst_mngr_if.master: request handshake, W channel,
//          finish_wd/finish_id completion pulse
//
// Build option:
//   WDATA_BURST_MNGR_QUEUE_EN defined   -> 2-entry burst FIFO, req_ready = not full
//   WDATA_BURST_MNGR_QUEUE_EN undefined -> single entry,
//                                          req_ready = idle | final handshake
// -----------------------------------------------------------------------------
module wdata_burst_mngr #(
  parameter int DATA_W = 32,
  parameter int BEATS  = 4,
  parameter int ID_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  wdata_burst_mngr_if.master bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(BEATS);
`ifdef WDATA_BURST_MNGR_QUEUE_EN
  localparam int DEPTH  = 2;
`else
  localparam int DEPTH  = 1;
`endif

  typedef enum logic {IDLE, BURST} state_t;

  state_t                   state_reg, state_next;
  logic [CNT_W-1:0]         beat_reg, beat_next;
  logic [1:0]               count_reg, count_next, wr_idx;
  logic                     push, pop, req_ready_int;

  // Slot 0 is always the burst in flight; further slots are queued bursts.
  logic [ID_W-1:0]          slot_id_reg   [DEPTH];
  logic [ID_W-1:0]          slot_id_next  [DEPTH];
  logic [DATA_W*BEATS-1:0]  slot_data_reg [DEPTH];
  logic [DATA_W*BEATS-1:0]  slot_data_next[DEPTH];
  logic [STRB_W*BEATS-1:0]  slot_mask_reg [DEPTH];
  logic [STRB_W*BEATS-1:0]  slot_mask_next[DEPTH];

  // Contents of the slot above each slot (zero above the top slot).
  logic [DEPTH-1:0][ID_W-1:0]         slot_id_up;
  logic [DEPTH-1:0][DATA_W*BEATS-1:0] slot_data_up;
  logic [DEPTH-1:0][STRB_W*BEATS-1:0] slot_mask_up;

  logic                     wvalid_reg, wlast_reg;
  logic [DATA_W-1:0]        wdata_reg;
  logic [STRB_W-1:0]        wstrb_reg;
  logic [ID_W-1:0]          finish_id_reg;

  // Final beat handshake retires the burst in slot 0.
  assign pop  = wvalid_reg & bus.wready & wlast_reg;

`ifdef WDATA_BURST_MNGR_QUEUE_EN
  assign req_ready_int = (count_reg != 2'(DEPTH));
`else
  assign req_ready_int = (state_reg == IDLE) | pop;
`endif

  assign push       = bus.req_valid & req_ready_int;
  assign count_next = count_reg + {1'b0, push} - {1'b0, pop};
  // Write position accounts for the shift-down caused by a simultaneous pop.
  assign wr_idx     = count_reg - {1'b0, pop};

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_up
      if (gi == DEPTH - 1) begin : g_top
        assign slot_id_up[gi]   = '0;
        assign slot_data_up[gi] = '0;
        assign slot_mask_up[gi] = '0;
      end else begin : g_mid
        assign slot_id_up[gi]   = slot_id_reg[gi+1];
        assign slot_data_up[gi] = slot_data_reg[gi+1];
        assign slot_mask_up[gi] = slot_mask_reg[gi+1];
      end
    end
  endgenerate

  // Shift-register FIFO: pop moves every slot down, push fills the first free one.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slot_id_next[i]   = pop ? slot_id_up[i]   : slot_id_reg[i];
      slot_data_next[i] = pop ? slot_data_up[i] : slot_data_reg[i];
      slot_mask_next[i] = pop ? slot_mask_up[i] : slot_mask_reg[i];
      if (push && (wr_idx == 2'(i))) begin
        slot_id_next[i]   = bus.req_id;
        slot_data_next[i] = bus.req_wdata;
        slot_mask_next[i] = bus.req_mask;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    case (state_reg)
      IDLE: begin
        if (push) begin
          state_next = BURST;
          beat_next  = '0;
        end
      end
      BURST: begin
        if (wvalid_reg && bus.wready) begin
          // Power-of-two BEATS: natural wrap returns to beat 0 after the last.
          beat_next = beat_reg + 1'b1;
          if (wlast_reg && (count_next == 2'd0)) begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        beat_next  = '0;
      end
    endcase
  end

  // W-channel outputs are registered from next-state values so they stay
  // glitch-free and hold naturally while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      beat_reg      <= '0;
      count_reg     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_id_reg[i]   <= '0;
        slot_data_reg[i] <= '0;
        slot_mask_reg[i] <= '0;
      end
      wvalid_reg    <= 1'b0;
      wlast_reg     <= 1'b0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      finish_id_reg <= '0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
      count_reg <= count_next;
      for (int i = 0; i < DEPTH; i++) begin
        slot_id_reg[i]   <= slot_id_next[i];
        slot_data_reg[i] <= slot_data_next[i];
        slot_mask_reg[i] <= slot_mask_next[i];
      end
      wvalid_reg <= (state_next == BURST);
      wlast_reg  <= (state_next == BURST) && (beat_next == CNT_W'(BEATS - 1));
      if (state_next == BURST) begin
        wdata_reg     <= slot_data_next[0][32'(beat_next) * DATA_W +: DATA_W];
        wstrb_reg     <= ~slot_mask_next[0][32'(beat_next) * STRB_W +: STRB_W];
        finish_id_reg <= slot_id_next[0];
      end else begin
        wdata_reg <= '0;
        wstrb_reg <= '0;
      end
    end
  end

  assign bus.req_ready = req_ready_int;
  assign bus.wvalid    = wvalid_reg;
  assign bus.wdata     = wdata_reg;
  assign bus.wstrb     = wstrb_reg;
  assign bus.wlast     = wlast_reg;
  assign bus.finish_wd = wvalid_reg & bus.wready & wlast_reg;
  assign bus.finish_id = finish_id_reg;

endmodule

// File: tb/tb_wdata_burst_mngr.sv
// -----------------------------------------------------------------------------
// tb_wdata_burst_mngr
// Scoreboard bench: each accepted request pushes its expected beats; every
// W handshake pops and compares. A second instance covers BEATS=8/DATA_W=64.
// -----------------------------------------------------------------------------
module tb_wdata_burst_mngr;
  localparam int DATA_W = 32;
  localparam int BEATS  = 4;
  localparam int ID_W   = 4;
  localparam int STRB_W = DATA_W / 8;
  localparam int D8_W   = 64;
  localparam int B8     = 8;
  localparam int S8     = D8_W / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wdata_burst_mngr_if #(.DATA_W(DATA_W), .BEATS(BEATS), .ID_W(ID_W)) bus ();
  wdata_burst_mngr_if #(.DATA_W(D8_W), .BEATS(B8), .ID_W(ID_W)) bus8 ();

  wdata_burst_mngr #(.DATA_W(DATA_W), .BEATS(BEATS), .ID_W(ID_W)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  wdata_burst_mngr #(.DATA_W(D8_W), .BEATS(B8), .ID_W(ID_W)) u_dut8 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus8)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic              last;
    logic [ID_W-1:0]   id;
  } beat_t;

  beat_t sb[$];
  int    err_cnt = 0;
  int    chk_cnt = 0;
  int    wr_mode = 0;   // 0: wready=1, 1: random, 2: driven by the test

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (wr_mode == 0) bus.wready = 1'b1;
    else if (wr_mode == 1) bus.wready = 1'($urandom_range(0, 1));
  endtask

  // Monitor / scoreboard, sampled on the falling edge.
  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data;
  logic [STRB_W-1:0] prev_strb;
  logic              prev_last;
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      sb.delete();
      prev_stall = 1'b0;
      chk("rst_wvalid", 64'(bus.wvalid), 64'd0);
      chk("rst_finish", 64'(bus.finish_wd), 64'd0);
    end else begin
      chk("wvalid", 64'(bus.wvalid), 64'(sb.size() != 0));
      if (prev_stall) begin
        chk("hold_wdata", 64'(bus.wdata), 64'(prev_data));
        chk("hold_wstrb", 64'(bus.wstrb), 64'(prev_strb));
        chk("hold_wlast", 64'(bus.wlast), 64'(prev_last));
      end
      prev_stall = bus.wvalid && !bus.wready;
      prev_data  = bus.wdata;
      prev_strb  = bus.wstrb;
      prev_last  = bus.wlast;
      if (bus.wvalid && bus.wready) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("wdata", 64'(bus.wdata), 64'(e.data));
          chk("wstrb", 64'(bus.wstrb), 64'(e.strb));
          chk("wlast", 64'(bus.wlast), 64'(e.last));
          chk("finish_wd", 64'(bus.finish_wd), 64'(e.last));
          if (e.last) begin
            chk("finish_id", 64'(bus.finish_id), 64'(e.id));
            $display("burst done id=%0d finish_id=%0d t=%0t", e.id, bus.finish_id, $time);
          end
        end
      end else begin
        chk("finish_idle", 64'(bus.finish_wd), 64'd0);
      end
      if (bus.req_valid && bus.req_ready) begin
        for (int k = 0; k < BEATS; k++) begin
          e.data = bus.req_wdata[k*DATA_W +: DATA_W];
          e.strb = ~bus.req_mask[k*STRB_W +: STRB_W];
          e.last = (k == BEATS - 1);
          e.id   = bus.req_id;
          sb.push_back(e);
        end
      end
    end
  end

  // Offer a request until accepted, then scramble the request bus.
  task automatic send_req(input logic [ID_W-1:0] id, input logic [127:0] data,
                          input logic [15:0] mask);
    bit acc = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_id    = id;
    bus.req_wdata = data;
    bus.req_mask  = mask;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      acc = bus.req_ready;
      tick();
    end
    if (!acc) chk("req_timeout", 64'd0, 64'd1);
    bus.req_valid = 1'b0;
    bus.req_id    = ID_W'($urandom);
    bus.req_wdata = {$urandom, $urandom, $urandom, $urandom};
    bus.req_mask  = 16'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || bus.wvalid) && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) chk("drain_timeout", 64'd0, 64'd1);
    tick();
  endtask

  localparam logic [127:0] REF_DATA = 128'h4444_4444_3333_3333_2222_2222_1111_1111;

  initial begin
    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [D8_W*B8-1:0] d8;

    bus.req_valid  = 1'b0;
    bus.req_id     = '0;
    bus.req_wdata  = '0;
    bus.req_mask   = '0;
    bus.wready     = 1'b1;
    bus8.req_valid = 1'b0;
    bus8.req_id    = '0;
    bus8.req_wdata = '0;
    bus8.req_mask  = '0;
    bus8.wready    = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_wlast", 64'(bus.wlast), 64'd0);
    chk("rst_wdata", 64'(bus.wdata), 64'd0);
    chk("rst_wstrb", 64'(bus.wstrb), 64'd0);
    chk("rst_finish_id", 64'(bus.finish_id), 64'd0);
    rst_n = 1'b1;
    tick();

    // Basic burst, wready held high.
    send_req(4'd5, REF_DATA, 16'h0000);
    chk("first_beat_data", 64'(bus.wdata), 64'h1111_1111);
    drain();

    // Stalls: wready 1,0,0,1,1,0,1 from the first beat.
    wr_mode = 2;
    bus.wready = 1'b1;
    send_req(4'd5, REF_DATA, 16'h0000);
    for (int i = 0; i < 7; i++) begin
      bus.wready = pat[i];
      tick();
    end
    wr_mode = 0;
    drain();

    // Byte masks.
    send_req(4'd3, {$urandom, $urandom, $urandom, $urandom}, 16'h0F00);
    drain();

    // Back-to-back requests offered continuously.
    send_req(4'd1, {$urandom, $urandom, $urandom, $urandom}, 16'h0000);
`ifdef WDATA_BURST_MNGR_QUEUE_EN
    chk("queue_ready", 64'(bus.req_ready), 64'd1);
`endif
    send_req(4'd2, {$urandom, $urandom, $urandom, $urandom}, 16'h00F0);
    drain();

    // Reset while beat 2 is on the bus.
    send_req(4'd7, {$urandom, $urandom, $urandom, $urandom}, 16'h0000);
    tick();
    tick();
    chk("pre_reset_last", 64'(bus.wlast), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_wvalid", 64'(bus.wvalid), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    send_req(4'd8, {$urandom, $urandom, $urandom, $urandom}, 16'h0000);
    drain();

    // Random traffic with random wready.
    wr_mode = 1;
    for (int t = 0; t < 8; t++) begin
      send_req(ID_W'($urandom), {$urandom, $urandom, $urandom, $urandom}, 16'($urandom));
      repeat ($urandom_range(0, 3)) tick();
    end
    wr_mode = 0;
    drain();

    // Wide/long configuration: BEATS=8, DATA_W=64.
    for (int k = 0; k < B8; k++) d8[k*D8_W +: D8_W] = {32'(k), 32'hA5A5_0000 | 32'(k)};
    bus8.req_id    = 4'd9;
    bus8.req_wdata = d8;
    bus8.req_mask  = '0;
    bus8.req_valid = 1'b1;
    @(negedge clk);
    chk("b8_ready", 64'(bus8.req_ready), 64'd1);
    tick();
    bus8.req_valid = 1'b0;
    bus8.req_wdata = '1;
    for (int k = 0; k < B8; k++) begin
      @(negedge clk);
      chk("b8_wvalid", 64'(bus8.wvalid), 64'd1);
      chk("b8_wdata", bus8.wdata, {32'(k), 32'hA5A5_0000 | 32'(k)});
      chk("b8_wstrb", 64'(bus8.wstrb), 64'hFF);
      chk("b8_wlast", 64'(bus8.wlast), 64'(k == B8 - 1));
      chk("b8_finish", 64'(bus8.finish_wd), 64'(k == B8 - 1));
      if (k == B8 - 1) chk("b8_finish_id", 64'(bus8.finish_id), 64'd9);
    end
    $display("burst done id=9 (BEATS=8 instance) t=%0t", $time);
    @(negedge clk);
    chk("b8_idle", 64'(bus8.wvalid), 64'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
